sht10_meas_scheduler: RTL

Sequences the SHT10 sensor driver (sht10_sensor) autonomously. Each measurement period it runs one temperature conversion and then one humidity conversion. It supervises each conversion for communication errors and timeouts. On failure it recovers with a connection-reset pulse and a bounded number of retries. It latches the raw results for the display/processing path.

---
 rtl/sht10_meas_scheduler.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/sht10_meas_scheduler.sv
// SHT10 measurement scheduler: periodic temperature/humidity conversions
// with error/timeout supervision, connection reset and bounded retries.
module sht10_meas_scheduler #(
    parameter int unsigned PERIOD_CYCLES  = 100000000,
    parameter int unsigned TIMEOUT_CYCLES = 40000000,
    parameter int unsigned RESET_CYCLES   = 1000,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    output logic        meas_start,
    output logic        meas_sel,
    output logic        conn_reset,
    input  logic        sensor_done,
    input  logic        sensor_error,
    input  logic [15:0] sensor_data,
    output logic [13:0] temp_raw,
    output logic [11:0] rh_raw,
    output logic        temp_valid,
    output logic        rh_valid,
    output logic        fault,
    output logic        busy,
    output logic [7:0]  err_count
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        LATCH,
        CONN_RST,
        WAIT_PERIOD
    } state_t;

    localparam logic [31:0] P_LAST   = 32'(PERIOD_CYCLES - 1);
    localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] RST_LAST = 32'(RESET_CYCLES - 1);
    localparam logic [7:0]  MR       = 8'(MAX_RETRY);

    state_t      r_state;
    state_t      w_next;
    state_t      w_after;
    logic        r_sel;
    logic [31:0] r_per_cnt;
    logic [31:0] r_to_cnt;
    logic [31:0] r_rst_cnt;
    logic [7:0]  r_retry;
    logic [7:0]  r_err_cnt;
    logic [13:0] r_temp;
    logic [11:0] r_rh;
    logic        r_temp_vld;
    logic        r_rh_vld;
    logic        r_fault;
    logic        w_fail;
    logic        w_ok;
    logic        w_retry;
    logic        w_adv;
    logic        w_per_clr;
    logic        w_unused;

    assign w_unused = ^sensor_data[15:14];

    always_comb begin
        w_fail = 1'b0;
        w_ok   = 1'b0;
        if (r_state == WAIT_DONE) begin
            // error beats done, done beats timeout
            w_fail = sensor_error ||
                     (!sensor_done && r_to_cnt == TO_LAST);
            w_ok   = !sensor_error && sensor_done;
        end
        w_retry = w_fail && (r_retry < MR);
        w_adv   = (r_state == LATCH) || (w_fail && !w_retry);
        if (r_sel)
            w_after = WAIT_PERIOD;
        else if (enable)
            w_after = ISSUE;
        else
            w_after = IDLE;

        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (enable)
                    w_next = ISSUE;
            end
            ISSUE: begin
                w_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (w_retry)
                    w_next = CONN_RST;
                else if (w_adv)
                    w_next = w_after;
                else if (w_ok)
                    w_next = LATCH;
            end
            LATCH: begin
                w_next = w_after;
            end
            CONN_RST: begin
                if (r_rst_cnt == RST_LAST)
                    w_next = ISSUE;
            end
            WAIT_PERIOD: begin
                if (!enable)
                    w_next = IDLE;
                else if (r_per_cnt == P_LAST)
                    w_next = ISSUE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase

        w_per_clr = (w_next == ISSUE) &&
                    (r_state == IDLE || r_state == WAIT_PERIOD);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_sel      <= 1'b0;
            r_per_cnt  <= '0;
            r_to_cnt   <= '0;
            r_rst_cnt  <= '0;
            r_retry    <= '0;
            r_err_cnt  <= '0;
            r_temp     <= '0;
            r_rh       <= '0;
            r_temp_vld <= 1'b0;
            r_rh_vld   <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_temp_vld <= 1'b0;
            r_rh_vld   <= 1'b0;

            if (r_state == IDLE)
                r_sel <= 1'b0;
            else if (w_adv)
                r_sel <= !r_sel && enable;

            // period count saturates so an overrun restarts at once
            if (w_per_clr)
                r_per_cnt <= '0;
            else if (r_per_cnt != P_LAST)
                r_per_cnt <= r_per_cnt + 32'd1;

            if (r_state == WAIT_DONE)
                r_to_cnt <= r_to_cnt + 32'd1;
            else
                r_to_cnt <= '0;

            if (r_state == CONN_RST)
                r_rst_cnt <= r_rst_cnt + 32'd1;
            else
                r_rst_cnt <= '0;

            if (r_state == IDLE || w_adv)
                r_retry <= '0;
            else if (w_retry)
                r_retry <= r_retry + 8'd1;

            if (w_fail && r_err_cnt != 8'hFF)
                r_err_cnt <= r_err_cnt + 8'd1;

            if (r_state == IDLE && enable)
                r_fault <= 1'b0;
            else if (w_fail && !w_retry)
                r_fault <= 1'b1;

            if (w_ok && !r_sel) begin
                r_temp     <= sensor_data[13:0];
                r_temp_vld <= 1'b1;
            end
            if (w_ok && r_sel) begin
                r_rh     <= sensor_data[11:0];
                r_rh_vld <= 1'b1;
            end
        end
    end

    assign meas_start = (r_state == ISSUE);
    assign meas_sel   = r_sel;
    assign conn_reset = (r_state == CONN_RST);
    assign busy       = (r_state != IDLE) && (r_state != WAIT_PERIOD);
    assign temp_raw   = r_temp;
    assign rh_raw     = r_rh;
    assign temp_valid = r_temp_vld;
    assign rh_valid   = r_rh_vld;
    assign fault      = r_fault;
    assign err_count  = r_err_cnt;

endmodule
